// File: rtl/ram_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_master_pkg
// Purpose  : Shared types and default widths for the ram_bus_master block.
//            state_e lists every controller state; ST_INIT is only reached
//            when the design is built with RAM_MASTER_INIT_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
package ram_master_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_INIT    = 3'd4
  } state_e;

endpackage : ram_master_pkg
`default_nettype wire

// File: rtl/ram_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_master_if
// Purpose  : Request/response stream between a client and ram_bus_master.
// Ports    : req_valid/req_ready handshake with req_we, req_addr, req_wdata;
//            rsp_valid one-cycle pulse qualifying rsp_rdata.
//            modport master : client side (drives requests)
//            modport slave  : ram_bus_master side (accepts requests)
// Revision : 1.0 - initial release
// ============================================================================
interface ram_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface : ram_bus_master_if
`default_nettype wire

// File: rtl/single_port_sync_ram.sv
`default_nettype none
// ============================================================================
// Module   : single_port_sync_ram
// Purpose  : Synchronous single-port RAM with a shared tri-state data bus.
//            Write on clk edge when cs & we; read data registered on clk edge
//            when cs & ~we and driven onto the bus while cs & oe & ~we.
// Ports    : clk, cs, we, oe, addr[ADDR_WIDTH], data[DATA_WIDTH] (inout)
// Revision : 1.0 - initial release
// ============================================================================
module single_port_sync_ram #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) begin
        mem_q[addr] <= data;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign data = (cs && oe && !we) ? rdata_q : {DATA_WIDTH{1'bz}};

endmodule : single_port_sync_ram
`default_nettype wire

// File: rtl/ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : ram_bus_master
// Purpose  : Converts a valid/ready read/write request stream into cs/we/oe/
//            addr cycles on a single_port_sync_ram shared data bus, owns bus
//            direction and returns read data as a one-cycle rsp_valid pulse.
//            Writes: 1 per cycle. Reads: accept -> rsp_valid 3 cycles later.
// Ports    : clk, rst (sync, active-high)
//            req_if  (ram_bus_master_if.slave) request / response stream
//            ram_cs, ram_we, ram_oe, ram_addr, ram_data (inout) RAM pins
// Options  : RAM_MASTER_INIT_EN - after reset, zero-fill all DEPTH words
//            (req_ready held low) before entering IDLE.
// Revision : 1.0 - initial release
// ============================================================================
module ram_bus_master
  import ram_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_bus_master_if.slave       req_if,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  generate
    if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_depth_check
      $error("ram_bus_master: DEPTH must equal 2**ADDR_WIDTH");
    end
  endgenerate

  state_e                state_q,     state_d;
  logic                  ram_cs_q,    ram_cs_d;
  logic                  ram_we_q,    ram_we_d;
  logic                  ram_oe_q,    ram_oe_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_MASTER_INIT_EN
  // One extra bit so the counter can reach DEPTH and mark the fill complete.
  logic [ADDR_WIDTH:0]   init_cnt_q,  init_cnt_d;
`endif

  logic accept;

  // Ready depends on state only, so a client may drive req_valid from req_ready.
  assign req_if.req_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
  assign accept           = req_if.req_valid && req_if.req_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM_MASTER_INIT_EN
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
`else
      state_q    <= ST_IDLE;
`endif
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_addr_q  <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
`ifdef RAM_MASTER_INIT_EN
      init_cnt_q  <= init_cnt_d;
`endif
      ram_cs_q    <= ram_cs_d;
      ram_we_q    <= ram_we_d;
      ram_oe_q    <= ram_oe_d;
      ram_addr_q  <= ram_addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
`ifdef RAM_MASTER_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (accept) begin
          state_d = req_if.req_we ? ST_WRITE : ST_RD_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = ST_IDLE;
`ifdef RAM_MASTER_INIT_EN
      ST_INIT: begin
        if (init_cnt_q == (ADDR_WIDTH + 1)'(DEPTH)) begin
          state_d = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- outputs
  // Pin registers are loaded from the state being entered, so the bus
  // pattern on the pins always matches the registered state.
  always_comb begin
    ram_cs_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_oe_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_d)
      ST_WRITE: begin
        ram_cs_d   = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = req_if.req_addr;
        wdata_d    = req_if.req_wdata;
      end
      ST_RD_ADDR: begin
        ram_cs_d   = 1'b1;
        ram_oe_d   = 1'b1;
        ram_addr_d = req_if.req_addr;
      end
      ST_RD_DATA: begin
        ram_cs_d = 1'b1;
        ram_oe_d = 1'b1;
      end
`ifdef RAM_MASTER_INIT_EN
      ST_INIT: begin
        ram_cs_d   = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = init_cnt_q[ADDR_WIDTH-1:0];
        wdata_d    = '0;
      end
`endif
      default: ;
    endcase
    // RAM has driven its registered word for the whole RD_DATA cycle.
    if (state_q == ST_RD_DATA) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = ram_data;
    end
  end

  assign ram_cs   = ram_cs_q;
  assign ram_we   = ram_we_q;
  assign ram_oe   = ram_oe_q;
  assign ram_addr = ram_addr_q;

  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_rdata = rsp_rdata_q;

  // Master drives only during write cycles; released as soon as oe rises.
  assign ram_data = (ram_we_q && !ram_oe_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule : ram_bus_master
`default_nettype wire

// File: tb/tb_ram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bus_master
// Purpose  : Scoreboard bench for ram_bus_master + single_port_sync_ram.
//            Request driver pushes expected reads/writes into queues; a
//            negedge monitor pops and compares rsp and RAM write cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bus_master;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  ram_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_if   (bus),
    .ram_cs   (ram_cs),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  single_port_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .cs   (ram_cs),
    .we   (ram_we),
    .oe   (ram_oe),
    .addr (ram_addr),
    .data (ram_data)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            acc_cyc;
  } rd_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  rd_exp_t       rdq[$];
  wr_exp_t       wrq[$];
  logic [DW-1:0] model [DEPTH];

  int total      = 0;
  int bad        = 0;
  int cyc        = 0;
  int rsp_count  = 0;
  int we_run     = 0;
  int we_run_max = 0;
  int last_acc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin : mon
    rd_exp_t e;
    wr_exp_t w;
    if (rst) begin
      we_run = 0;
    end else begin
      if (bus.rsp_valid) begin
        rsp_count++;
        if (rdq.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          e = rdq.pop_front();
          check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.data));
          check("rsp_latency", 64'(cyc - e.acc_cyc), 64'd3);
        end
      end
      if (ram_cs && ram_we) begin
        we_run++;
        if (we_run > we_run_max) we_run_max = we_run;
        if (wrq.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          w = wrq.pop_front();
          check("wr_addr", 64'(ram_addr), 64'(w.addr));
          check("wr_data", 64'(ram_data), 64'(w.data));
          check("wr_oe_low", 64'(ram_oe), 64'd0);
        end
      end else begin
        we_run = 0;
      end
    end
  end

  // -------------------------------------------------------------- driver
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    int guard = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      return;
    end
    if (we) begin
      wrq.push_back(wr_exp_t'{addr, data});
      model[addr] = data;
    end else begin
      rdq.push_back(rd_exp_t'{model[addr], cyc});
    end
    last_acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic post_reset();
    int g = 0;
    rdq.delete();
    wrq.delete();
`ifdef RAM_MASTER_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      wrq.push_back(wr_exp_t'{AW'(i), '0});
      model[i] = '0;
    end
`endif
    while (!bus.req_ready && g < 64) begin
      @(negedge clk);
      g++;
    end
    check("ready_after_reset", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int prev;
    int rsp_before;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", 64'(ram_cs), 64'd0);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_oe", 64'(ram_oe), 64'd0);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    rst = 1'b0;
    post_reset();

    // 16 back-to-back writes
    for (int i = 0; i < DEPTH; i++) begin
      check("b2b_ready", 64'(bus.req_ready), 64'd1);
      issue(1'b1, AW'(i), 32'hA5A5_0000 + 32'(i));
    end
    idle(2);
    check("we_run_len", 64'(we_run_max), 64'd16);

    // 16 reads, one per 3 cycles
    prev = 0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, AW'(i), '0);
      if (i > 0) check("rd_spacing", 64'(last_acc - prev), 64'd3);
      prev = last_acc;
    end
    idle(4);
    check("last_read_a5", 64'(bus.rsp_rdata), 64'hA5A5_000F);

    // Write immediately followed by read of the same address
    issue(1'b1, 4'd7, 32'hDEAD_BEEF);
    issue(1'b0, 4'd7, '0);
    idle(4);
    check("wr_then_rd", 64'(bus.rsp_rdata), 64'hDEAD_BEEF);

    // Reset mid-read: response must be dropped
    issue(1'b1, 4'd3, 32'h1234_5678);
    issue(1'b0, 4'd3, '0);
    rst = 1'b1;
    rdq.delete();
    wrq.delete();
    rsp_before = rsp_count;
    repeat (3) @(negedge clk);
    check("mid_rst_cs", 64'(ram_cs), 64'd0);
    check("mid_rst_oe", 64'(ram_oe), 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid_rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    rst = 1'b0;
    post_reset();
    idle(5);
    check("dropped_rsp", 64'(rsp_count), 64'(rsp_before));

    // 200 mixed operations with random gaps
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    end
    idle(6);

    // Drain
    for (int g = 0; g < 20 && (rdq.size() != 0 || wrq.size() != 0); g++) @(negedge clk);
    check("drain_rd", 64'(rdq.size()), 64'd0);
    check("drain_wr", 64'(wrq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_bus_master
`default_nettype wire

// File: doc/ram_bus_master.md
Name: ram_bus_master

Overview:
Bus initiator for single_port_sync_ram: converts a valid/ready request stream (read or write) into cs/we/oe/addr cycles on the RAM's shared tri-state data bus. Owns bus direction, read-capture timing and read response return. Sits between any client (DMA, CPU shim, bench driver) and the RAM instance.

Parameters:
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 32, RAM data width
DEPTH, 16, RAM words (must equal 2**ADDR_WIDTH)

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  master can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle pulse, rsp_rdata valid
rsp_rdata  output  DATA_WIDTH  read data
ram_cs  output  1  RAM chip select
ram_we  output  1  RAM write enable
ram_oe  output  1  RAM output enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_data  inout  DATA_WIDTH  shared bus; driven by master only when ram_we=1 and ram_oe=0, else hi-Z

Behaviour:
- Reset (rst=1 at edge): state IDLE; ram_cs/ram_we/ram_oe=0, ram_addr=0, ram_data hi-Z, rsp_valid=0, rsp_rdata=0. In-flight read discarded, no rsp_valid.
- ram_cs/we/oe/addr, write-data register, rsp_* all registered; req_ready combinational from state only (never from req_valid).
- States: IDLE, WRITE, RD_ADDR, RD_DATA.
- req_ready=1 in IDLE and WRITE; 0 in RD_ADDR, RD_DATA.
- Accept = req_valid & req_ready at an edge; req_* sampled only then.
- Write accepted -> WRITE next cycle: cs=1, we=1, oe=0, addr/data driven; RAM stores at following edge. Write accepted in WRITE -> stays WRITE (back-to-back writes, 1/cycle). No accept in WRITE -> IDLE, all controls 0.
- Read accepted (IDLE or WRITE) -> RD_ADDR: cs=1, we=0, oe=1, addr driven, bus released same cycle oe rises (no contention). Next edge -> RD_DATA (cs/oe held). Edge ending RD_DATA: ram_data captured into rsp_rdata, rsp_valid=1 for exactly the following cycle, state -> IDLE (req_ready=1 in same cycle as rsp_valid).
- Read latency: accept edge E0 -> rsp_valid high in cycle after E2. Read throughput 1 per 3 cycles.
- Write-then-read same address: read returns newly written data.
- rsp_rdata holds last read value until next capture.
- Address wraps naturally at ADDR_WIDTH; no range check.

Optional Feature:
RAM_MASTER_INIT_EN defined: after reset leaves, extra state INIT writes 0 to addresses 0..DEPTH-1, one per cycle (cs=1, we=1, oe=0), req_ready=0 throughout, then IDLE; rst during INIT restarts from address 0. Undefined: no INIT state, IDLE directly after reset, RAM contents untouched.

Decomposition:
- Package ram_master_pkg: state enum (IDLE, WRITE, RD_ADDR, RD_DATA, INIT), default ADDR_WIDTH/DATA_WIDTH constants.
- No sub-module; tri-state driver is a single continuous assign in the top. Bench instantiates ram_bus_master + single_port_sync_ram.

Test Plan:
- Reset: hold rst 3 cycles mid-traffic -> all controls 0, ram_data hi-Z, rsp_valid never pulses for dropped read.
- 16 back-to-back writes addr 0..15, data 0xA5A5_0000+i, req_valid held -> req_ready stays 1, ram_we high 16 consecutive cycles.
- Read addr 0..15 -> rsp_rdata = 0xA5A5_0000+i in order, rsp_valid exactly 3 cycles after each accept, req_ready low 2 cycles per read.
- Write 0xDEAD_BEEF to addr 7 immediately followed by read addr 7 -> rsp_rdata=0xDEAD_BEEF; no X on ram_data at turnaround.
- req_valid toggling randomly, 200 mixed ops vs reference model -> all reads match, no accept while req_ready=0.
- RAM_MASTER_INIT_EN: after reset req_ready=0 for 16 cycles, then reads of addr 0..15 all return 0x0000_0000.
